demux_buf: RTL and testbench

DEMUX_BUF -- requirements
Module: demux_buf

---
 rtl/demux_buf.sv | 105 ++++++++++
 tb/tb_demux_buf.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/demux_buf.sv
// One-input, two-output demultiplexer with a one-entry skid register per output.
// A per-output counter tracks completed output transfers and wraps silently.
module demux_buf #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  input  logic             sig,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_0,
  output logic             out_0_valid,
  input  logic             out_0_ready,
  output logic [WIDTH-1:0] out_1,
  output logic             out_1_valid,
  input  logic             out_1_ready,
  output logic [CNT_W-1:0] cnt_0,
  output logic [CNT_W-1:0] cnt_1
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } bufState_t;

  bufState_t        r_state0;
  bufState_t        r_state1;
  bufState_t        w_next0;
  bufState_t        w_next1;
  logic [WIDTH-1:0] r_data0;
  logic [WIDTH-1:0] r_data1;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  logic w_drain0;
  logic w_drain1;
  logic w_room0;
  logic w_room1;
  logic w_load0;
  logic w_load1;

  assign w_drain0 = (r_state0 == FULL) && out_0_ready;
  assign w_drain1 = (r_state1 == FULL) && out_1_ready;

  // A slot can take a word if it is empty or is being emptied on this same edge.
  assign w_room0  = (r_state0 == EMPTY) || w_drain0;
  assign w_room1  = (r_state1 == EMPTY) || w_drain1;

  assign in_ready = sig ? w_room1 : w_room0;

  // Loads are gated by in_valid first so an unknown sig cannot leak into state.
  assign w_load0  = in_valid && !sig && w_room0;
  assign w_load1  = in_valid &&  sig && w_room1;

  always_comb begin
    w_next0 = r_state0;
    w_next1 = r_state1;
    if (w_load0) begin
      w_next0 = FULL;
    end else if (w_drain0) begin
      w_next0 = EMPTY;
    end
    if (w_load1) begin
      w_next1 = FULL;
    end else if (w_drain1) begin
      w_next1 = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state0 <= EMPTY;
      r_state1 <= EMPTY;
      r_data0  <= '0;
      r_data1  <= '0;
      r_cnt0   <= '0;
      r_cnt1   <= '0;
    end else begin
      r_state0 <= w_next0;
      r_state1 <= w_next1;
      if (w_load0) begin
        r_data0 <= in;
      end
      if (w_load1) begin
        r_data1 <= in;
      end
      if (w_drain0) begin
        r_cnt0 <= r_cnt0 + 1'b1;
      end
      if (w_drain1) begin
        r_cnt1 <= r_cnt1 + 1'b1;
      end
    end
  end

  assign out_0       = r_data0;
  assign out_1       = r_data1;
  assign out_0_valid = (r_state0 == FULL);
  assign out_1_valid = (r_state1 == FULL);
  assign cnt_0       = r_cnt0;
  assign cnt_1       = r_cnt1;

endmodule

// File: tb/tb_demux_buf.sv
// Scoreboard bench for demux_buf: directed stimulus pushes expected words,
// an independent monitor pops and compares them on every output handshake.
module tb_demux_buf;

  localparam int WIDTH = 64;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] in = '0;
  logic             in_valid = 1'b0;
  logic             sig = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] out_0;
  logic             out_0_valid;
  logic             out_0_ready = 1'b0;
  logic [WIDTH-1:0] out_1;
  logic             out_1_valid;
  logic             out_1_ready = 1'b0;
  logic [CNT_W-1:0] cnt_0;
  logic [CNT_W-1:0] cnt_1;

  int assertCount = 0;
  int failCount   = 0;

  logic [WIDTH-1:0] expQ0[$];
  logic [WIDTH-1:0] expQ1[$];
  logic [CNT_W-1:0] expCnt0 = '0;
  logic [CNT_W-1:0] expCnt1 = '0;

  always #5 clk = ~clk;

  demux_buf #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in         (in),
    .in_valid   (in_valid),
    .sig        (sig),
    .in_ready   (in_ready),
    .out_0      (out_0),
    .out_0_valid(out_0_valid),
    .out_0_ready(out_0_ready),
    .out_1      (out_1),
    .out_1_valid(out_1_valid),
    .out_1_ready(out_1_ready),
    .cnt_0      (cnt_0),
    .cnt_1      (cnt_1)
  );

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                             input logic [WIDTH-1:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drives one cycle; expected words are queued when the accept is predicted.
  task automatic applyStimulus(input logic r, input logic v, input logic s,
                               input logic [WIDTH-1:0] d, input logic rd0,
                               input logic rd1, input logic expReady);
    rst         = r;
    in_valid    = v;
    sig         = s;
    in          = d;
    out_0_ready = rd0;
    out_1_ready = rd1;
    @(negedge clk);
    if (v) checkOutput("in_ready", WIDTH'(in_ready), WIDTH'(expReady));
    if (!r && v && expReady) begin
      if (s) expQ1.push_back(d);
      else   expQ0.push_back(d);
    end
    @(posedge clk);
    #1;
    if (r) begin
      expQ0.delete();
      expQ1.delete();
      expCnt0 = '0;
      expCnt1 = '0;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        checkOutput("cnt_0", WIDTH'(cnt_0), WIDTH'(expCnt0));
        checkOutput("cnt_1", WIDTH'(cnt_1), WIDTH'(expCnt1));
        if (out_0_valid && out_0_ready) begin
          if (expQ0.size() == 0) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL out_0 unexpected word: got %h, expected none", out_0);
          end else begin
            checkOutput("out_0 data", out_0, expQ0.pop_front());
          end
          expCnt0 = expCnt0 + 1'b1;
        end
        if (out_1_valid && out_1_ready) begin
          if (expQ1.size() == 0) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL out_1 unexpected word: got %h, expected none", out_1);
          end else begin
            checkOutput("out_1 data", out_1, expQ1.pop_front());
          end
          expCnt1 = expCnt1 + 1'b1;
        end
      end
    end
  end

  initial begin
    applyStimulus(1, 0, 0, '0, 0, 0, 0);
    applyStimulus(1, 0, 0, '0, 0, 0, 0);
    checkOutput("reset in_ready", WIDTH'(in_ready), 1);
    checkOutput("reset out_0_valid", WIDTH'(out_0_valid), 0);
    checkOutput("reset out_1_valid", WIDTH'(out_1_valid), 0);
    checkOutput("reset out_0", out_0, 0);
    checkOutput("reset out_1", out_1, 0);
    checkOutput("reset cnt_0", WIDTH'(cnt_0), 0);
    checkOutput("reset cnt_1", WIDTH'(cnt_1), 0);

    applyStimulus(0, 1, 0, 64'h0, 0, 0, 1);
    checkOutput("route0 valid", WIDTH'(out_0_valid), 1);
    checkOutput("route0 data", out_0, 64'h0);
    checkOutput("route0 other valid", WIDTH'(out_1_valid), 0);

    applyStimulus(0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 1);
    checkOutput("route1 valid", WIDTH'(out_1_valid), 1);
    checkOutput("route1 data", out_1, 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("route1 out_0 held", out_0, 64'h0);
    checkOutput("route1 out_0 valid", WIDTH'(out_0_valid), 1);

    // Output 0 is stalled; sig=1 still reaches output 1 while it drains.
    applyStimulus(0, 1, 0, 64'hAAAA_AAAA_AAAA_AAAA, 0, 0, 0);
    checkOutput("bp out_0 held", out_0, 64'h0);
    applyStimulus(0, 1, 1, 64'h5555_5555_5555_5555, 0, 1, 1);
    checkOutput("bp out_1 replaced", out_1, 64'h5555_5555_5555_5555);
    checkOutput("bp out_1 valid", WIDTH'(out_1_valid), 1);
    checkOutput("bp cnt_1", WIDTH'(cnt_1), 1);
    applyStimulus(0, 0, 0, '0, 0, 1, 0);
    checkOutput("drain out_1 valid", WIDTH'(out_1_valid), 0);
    checkOutput("drain out_1 holds data", out_1, 64'h5555_5555_5555_5555);

    applyStimulus(1, 0, 0, '0, 0, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(0, 1, 0, WIDTH'(i), 1, 0, 1);
      checkOutput("stream out_0", out_0, WIDTH'(i));
      checkOutput("stream valid", WIDTH'(out_0_valid), 1);
    end
    applyStimulus(0, 0, 0, '0, 1, 0, 0);
    checkOutput("stream cnt_0", WIDTH'(cnt_0), 8);

    applyStimulus(1, 0, 0, '0, 0, 0, 0);
    for (int i = 0; i <= 256; i++) begin
      applyStimulus(0, 1, 1, WIDTH'(i), 0, 1, 1);
      if (i == 255) checkOutput("wrap cnt_1 all-ones", WIDTH'(cnt_1), 255);
    end
    checkOutput("wrap cnt_1 zero", WIDTH'(cnt_1), 0);
    checkOutput("wrap cnt_0 unchanged", WIDTH'(cnt_0), 0);
    applyStimulus(0, 0, 0, '0, 0, 1, 0);
    checkOutput("wrap cnt_1 after", WIDTH'(cnt_1), 1);

    applyStimulus(0, 1, 0, 64'h11, 0, 0, 1);
    applyStimulus(0, 1, 1, 64'h22, 0, 0, 1);
    applyStimulus(0, 0, 0, '0, 1, 1, 0);
    checkOutput("dual drain out_0 valid", WIDTH'(out_0_valid), 0);
    checkOutput("dual drain out_1 valid", WIDTH'(out_1_valid), 0);
    checkOutput("dual drain cnt_0", WIDTH'(cnt_0), 1);
    checkOutput("dual drain cnt_1", WIDTH'(cnt_1), 2);
    checkOutput("queue 0 empty", WIDTH'(expQ0.size()), 0);
    checkOutput("queue 1 empty", WIDTH'(expQ1.size()), 0);

    applyStimulus(0, 1, 0, 64'h33, 0, 0, 1);
    applyStimulus(0, 1, 1, 64'h44, 0, 0, 1);
    applyStimulus(1, 1, 0, 64'h77, 1, 1, 1);
    checkOutput("mid reset out_0_valid", WIDTH'(out_0_valid), 0);
    checkOutput("mid reset out_1_valid", WIDTH'(out_1_valid), 0);
    checkOutput("mid reset out_0", out_0, 0);
    checkOutput("mid reset out_1", out_1, 0);
    checkOutput("mid reset cnt_0", WIDTH'(cnt_0), 0);
    checkOutput("mid reset cnt_1", WIDTH'(cnt_1), 0);

    applyStimulus(0, 0, 1'bx, 'x, 0, 0, 0);
    checkOutput("x sig out_0_valid", WIDTH'(out_0_valid), 0);
    checkOutput("x sig out_1_valid", WIDTH'(out_1_valid), 0);
    checkOutput("x sig out_0", out_0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
